host_bus_interface: RTL and testbench

- Upstream neighbour of the blitter/register block.
- Converts the asynchronous 8-bit host CPU bus into single-cycle 16-bit register-write strobes: chip select, read/not-write, 4-bit register number, byte select and 8-bit data.
- Returns the byte-selected half of the 16-bit register read word to the host.
- All host inputs are asynchronous to clk. CS is synchronized; the other inputs are sampled once CS is known stable.

---
 rtl/host_bus_interface.sv | 123 ++++++++++++
 tb/tb_host_bus_interface.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_interface.sv
// Host CPU bus bridge: synchronizes the asynchronous 8-bit host bus chip select and turns
// each host access into a single 16-bit register write strobe or a byte-selected read.
module host_bus_interface #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic        bus_bytesel_i,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  output logic        reg_write_strobe_o,
  output logic [3:0]  reg_num_o,
  output logic [15:0] reg_data_o,
  input  logic [15:0] reg_data_i
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : gen_bad_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   cs_hist_q;
  logic                   cs_synced;
  logic                   cs_fall;

  logic                   pending_q;
  logic                   cap_rd_q;
  logic [3:0]             cap_num_q;
  logic                   cap_sel_q;
  logic [7:0]             cap_data_q;
  logic [7:0]             high_byte_q;

  logic [7:0]             bus_data_q;
  logic                   bus_data_oe_q;
  logic                   reg_write_strobe_q;
  logic [3:0]             reg_num_q;
  logic [15:0]            reg_data_q;

  // All stages reset to the asserted level so a CS held low across reset is not an edge.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_sync_q <= '0;
      cs_hist_q <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], bus_cs_n_i};
      cs_hist_q <= cs_synced;
    end
  end

  assign cs_synced = cs_sync_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_synced & cs_hist_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q            <= StIdle;
      pending_q          <= 1'b0;
      cap_rd_q           <= 1'b0;
      cap_num_q          <= '0;
      cap_sel_q          <= 1'b0;
      cap_data_q         <= '0;
      high_byte_q        <= '0;
      bus_data_q         <= '0;
      bus_data_oe_q      <= 1'b0;
      reg_write_strobe_q <= 1'b0;
      reg_num_q          <= '0;
      reg_data_q         <= '0;
    end else begin
      reg_write_strobe_q <= 1'b0;
      pending_q          <= 1'b0;
      case (state_q)
        StIdle: begin
          bus_data_oe_q <= 1'b0;
          if (cs_fall) begin
            cap_rd_q   <= bus_rd_nwr_i;
            cap_num_q  <= bus_reg_num_i;
            cap_sel_q  <= bus_bytesel_i;
            cap_data_q <= bus_data_i;
            pending_q  <= 1'b1;
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          if (cs_synced) begin
            // CS already gone again (runt pulse or end of access): no action, drop OE.
            bus_data_oe_q <= 1'b0;
            state_q       <= StIdle;
          end else begin
            if (pending_q) begin
              if (cap_rd_q) begin
                reg_num_q     <= cap_num_q;
                bus_data_oe_q <= 1'b1;
              end else if (cap_sel_q) begin
                reg_write_strobe_q <= 1'b1;
                reg_num_q          <= cap_num_q;
                reg_data_q         <= {high_byte_q, cap_data_q};
              end else begin
                high_byte_q <= cap_data_q;
              end
            end
            if (cap_rd_q) begin
              bus_data_q <= cap_sel_q ? reg_data_i[7:0] : reg_data_i[15:8];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_data_o         = bus_data_q;
  assign bus_data_oe_o      = bus_data_oe_q;
  assign reg_write_strobe_o = reg_write_strobe_q;
  assign reg_num_o          = reg_num_q;
  assign reg_data_o         = reg_data_q;

endmodule

// File: tb/tb_host_bus_interface.sv
// Directed bench for host_bus_interface: host writes, reads, runt pulses and reset behaviour.
module tb_host_bus_interface;

  localparam int unsigned SyncStages = 2;

  logic        clk;
  logic        reset_n_i;
  logic        bus_cs_n_i;
  logic        bus_rd_nwr_i;
  logic [3:0]  bus_reg_num_i;
  logic        bus_bytesel_i;
  logic [7:0]  bus_data_i;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic        reg_write_strobe_o;
  logic [3:0]  reg_num_o;
  logic [15:0] reg_data_o;
  logic [15:0] reg_data_i;

  int checks;
  int errors;
  int strobe_cnt;
  int oe_cnt;
  int stb_at;
  int oe_at;
  int oe_fall;
  int base_stb;
  int base_oe;

  host_bus_interface #(
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk               (clk),
    .reset_n_i         (reset_n_i),
    .bus_cs_n_i        (bus_cs_n_i),
    .bus_rd_nwr_i      (bus_rd_nwr_i),
    .bus_reg_num_i     (bus_reg_num_i),
    .bus_bytesel_i     (bus_bytesel_i),
    .bus_data_i        (bus_data_i),
    .bus_data_o        (bus_data_o),
    .bus_data_oe_o     (bus_data_oe_o),
    .reg_write_strobe_o(reg_write_strobe_o),
    .reg_num_o         (reg_num_o),
    .reg_data_o        (reg_data_o),
    .reg_data_i        (reg_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_write_strobe_o) strobe_cnt++;
    if (bus_data_oe_o) oe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n_i  = 1'b0;
    bus_cs_n_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (SyncStages + 4) @(negedge clk);
  endtask

  task automatic cs_release();
    bus_cs_n_i = 1'b1;
    oe_fall    = 0;
    for (int n = 1; n <= int'(SyncStages) + 4; n++) begin
      @(negedge clk);
      if (!bus_data_oe_o && oe_fall == 0) oe_fall = n;
    end
  endtask

  // Called right after a negedge; sample n follows the n-th posedge that sees CS low.
  task automatic access(input logic rd, input logic [3:0] num, input logic sel,
                        input logic [7:0] data, input int low_clks);
    bus_rd_nwr_i  = rd;
    bus_reg_num_i = num;
    bus_bytesel_i = sel;
    bus_data_i    = data;
    bus_cs_n_i    = 1'b0;
    stb_at        = 0;
    oe_at         = 0;
    base_stb      = strobe_cnt;
    base_oe       = oe_cnt;
    for (int n = 1; n <= low_clks; n++) begin
      @(negedge clk);
      if (reg_write_strobe_o && stb_at == 0) stb_at = n;
      if (bus_data_oe_o && oe_at == 0) oe_at = n;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    strobe_cnt    = 0;
    oe_cnt        = 0;
    reset_n_i     = 1'b0;
    bus_cs_n_i    = 1'b1;
    bus_rd_nwr_i  = 1'b0;
    bus_reg_num_i = '0;
    bus_bytesel_i = 1'b0;
    bus_data_i    = '0;
    reg_data_i    = '0;
    #12;
    check_eq("rst_data_o", {24'd0, bus_data_o}, 32'h0);
    check_eq("rst_oe", {31'd0, bus_data_oe_o}, 32'h0);
    check_eq("rst_strobe", {31'd0, reg_write_strobe_o}, 32'h0);
    check_eq("rst_reg_num", {28'd0, reg_num_o}, 32'h0);
    check_eq("rst_reg_data", {16'd0, reg_data_o}, 32'h0);
    do_reset();

    // High byte then low byte to reg 2.
    access(1'b0, 4'd2, 1'b0, 8'h1F, 8);
    check_eq("hi_no_strobe", strobe_cnt - base_stb, 0);
    cs_release();
    access(1'b0, 4'd2, 1'b1, 8'h20, 8);
    check_eq("wr_latency", stb_at, SyncStages + 2);
    check_eq("wr_strobe_cnt", strobe_cnt - base_stb, 1);
    check_eq("wr_reg_num", {28'd0, reg_num_o}, 32'h2);
    check_eq("wr_reg_data", {16'd0, reg_data_o}, 32'h1F20);
    check_eq("wr_no_oe", oe_cnt - base_oe, 0);
    cs_release();

    // Lone low byte after reset, then last high byte wins.
    do_reset();
    access(1'b0, 4'd1, 1'b1, 8'h34, 8);
    cs_release();
    check_eq("lone_strobe_cnt", strobe_cnt - base_stb, 1);
    check_eq("lone_reg_num", {28'd0, reg_num_o}, 32'h1);
    check_eq("lone_reg_data", {16'd0, reg_data_o}, 32'h0034);
    access(1'b0, 4'd1, 1'b0, 8'hAB, 8);
    cs_release();
    access(1'b0, 4'd1, 1'b0, 8'hCD, 8);
    cs_release();
    access(1'b0, 4'd1, 1'b1, 8'h01, 8);
    cs_release();
    check_eq("hihi_reg_data", {16'd0, reg_data_o}, 32'hCD01);

    // Reads of reg 2.
    reg_data_i = 16'hE3A5;
    access(1'b1, 4'd2, 1'b0, 8'h00, 8);
    check_eq("rd0_data", {24'd0, bus_data_o}, 32'hE3);
    check_eq("rd0_oe_rise", oe_at, SyncStages + 2);
    check_eq("rd0_reg_num", {28'd0, reg_num_o}, 32'h2);
    cs_release();
    check_eq("rd0_oe_fall", oe_fall, SyncStages + 1);
    check_eq("rd0_no_strobe", strobe_cnt - base_stb, 0);
    access(1'b1, 4'd2, 1'b1, 8'h00, 8);
    check_eq("rd1_data", {24'd0, bus_data_o}, 32'hA5);
    check_eq("rd1_oe", {31'd0, bus_data_oe_o}, 32'h1);
    cs_release();
    check_eq("rd1_no_strobe", strobe_cnt - base_stb, 0);
    check_eq("rd1_oe_off", {31'd0, bus_data_oe_o}, 32'h0);

    // reg_data_i changes mid-read.
    access(1'b1, 4'd2, 1'b1, 8'h00, 6);
    check_eq("mid_before", {24'd0, bus_data_o}, 32'hA5);
    reg_data_i = 16'h1234;
    @(negedge clk);
    check_eq("mid_after", {24'd0, bus_data_o}, 32'h34);
    cs_release();

    // Long CS low: still exactly one write.
    access(1'b0, 4'd7, 1'b1, 8'h5A, 40);
    cs_release();
    check_eq("long_strobe_cnt", strobe_cnt - base_stb, 1);
    check_eq("long_reg_data", {16'd0, reg_data_o}, 32'hCD5A);

    // One-clock runt pulse: nothing happens.
    access(1'b0, 4'd3, 1'b1, 8'h99, 1);
    cs_release();
    check_eq("runt_wr_strobe", strobe_cnt - base_stb, 0);
    check_eq("runt_wr_reg_num", {28'd0, reg_num_o}, 32'h7);
    access(1'b1, 4'd3, 1'b1, 8'h00, 1);
    cs_release();
    check_eq("runt_rd_oe", oe_cnt - base_oe, 0);

    // Reset during a read with OE high, CS held low through reset release.
    access(1'b1, 4'd2, 1'b0, 8'h00, 6);
    check_eq("rr_oe_before", {31'd0, bus_data_oe_o}, 32'h1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_eq("rr_oe_async", {31'd0, bus_data_oe_o}, 32'h0);
    check_eq("rr_data_async", {24'd0, bus_data_o}, 32'h0);
    @(negedge clk);
    reset_n_i = 1'b1;
    base_stb  = strobe_cnt;
    base_oe   = oe_cnt;
    repeat (10) @(negedge clk);
    check_eq("rr_held_low_oe", oe_cnt - base_oe, 0);
    check_eq("rr_held_low_stb", strobe_cnt - base_stb, 0);
    cs_release();
    access(1'b0, 4'd5, 1'b1, 8'h77, 8);
    cs_release();
    check_eq("rr_new_strobe", strobe_cnt - base_stb, 1);
    check_eq("rr_new_reg_num", {28'd0, reg_num_o}, 32'h5);
    check_eq("rr_new_reg_data", {16'd0, reg_data_o}, 32'h0077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
